// File: rtl/conv_window_ctrl.sv
// Line-buffer controller for the 3x3 convolver: four rotating row buffers on the write side,
// and a read scheduler that emits W-2 packed windows per buffered row triple.
module conv_window_ctrl #(
    parameter int INTEGER_BITS     = 8,
    parameter int FIXED_POINT_BITS = 4,
    parameter int IMG_WIDTH        = 512,
    localparam int DATA_W          = INTEGER_BITS + FIXED_POINT_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_W-1:0]     i_pixel_data,
    input  logic                  i_pixel_data_valid,
    output logic                  o_ready,
    input  logic                  i_window_ready,
    output logic [DATA_W*9-1:0]   o_pixel_data,
    output logic                  o_pixel_data_valid,
    output logic                  o_intr
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int CNT_W = $clog2(4 * IMG_WIDTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(4 * IMG_WIDTH);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(3 * IMG_WIDTH);
    localparam logic [CNT_W-1:0] ROW_CNT   = CNT_W'(IMG_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] LAST_WIN  = COL_W'(IMG_WIDTH - 3);

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } state_t;

    state_t              state_reg, state_next;
    logic [COL_W-1:0]    wr_col_reg, wr_col_next;
    logic [COL_W-1:0]    rd_col_reg, rd_col_next;
    logic [1:0]          wr_sel_reg, wr_sel_next;
    logic [1:0]          rd_sel_reg, rd_sel_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [DATA_W*9-1:0] window_reg;
    logic [DATA_W*9-1:0] window_rd;
    logic                valid_reg;
    logic                intr_reg;

    logic ready;
    logic accept;
    logic issue;
    logic row_complete;

    // Three adjacent columns of every buffer, leftmost column in the low bits.
    logic [3*DATA_W-1:0] rd_row [4];

    assign ready  = !i_rst && (count_reg < FULL_CNT);
    assign accept = i_pixel_data_valid && ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [IMG_WIDTH];

            always_ff @(posedge i_clk) begin
                if (accept && (wr_sel_reg == 2'(gi))) begin
                    mem[wr_col_reg] <= i_pixel_data;
                end
            end

            assign rd_row[gi] = {mem[rd_col_reg + COL_W'(2)],
                                 mem[rd_col_reg + COL_W'(1)],
                                 mem[rd_col_reg]};
        end
    endgenerate

    // Window row r comes from the r-th oldest buffer relative to rd_sel.
    always_comb begin
        window_rd = '0;
        for (int r = 0; r < 3; r++) begin
            window_rd[r*3*DATA_W +: 3*DATA_W] = rd_row[rd_sel_reg + 2'(r)];
        end
    end

    always_comb begin
        wr_col_next = wr_col_reg;
        wr_sel_next = wr_sel_reg;
        if (accept) begin
            if (wr_col_reg == LAST_COL) begin
                wr_col_next = '0;
                wr_sel_next = wr_sel_reg + 2'd1;
            end else begin
                wr_col_next = wr_col_reg + COL_W'(1);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_col_next  = rd_col_reg;
        rd_sel_next  = rd_sel_reg;
        issue        = 1'b0;
        row_complete = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg >= START_CNT) begin
                    state_next  = ST_READ;
                    rd_col_next = '0;
                end
            end
            ST_READ: begin
                if (i_window_ready) begin
                    issue = 1'b1;
                    if (rd_col_reg == LAST_WIN) begin
                        row_complete = 1'b1;
                        state_next   = ST_IDLE;
                        rd_col_next  = '0;
                        rd_sel_next  = rd_sel_reg + 2'd1;
                    end else begin
                        rd_col_next = rd_col_reg + COL_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Accept and retire may land in the same cycle; both terms apply.
    always_comb begin
        count_next = count_reg + (accept ? CNT_W'(1) : '0) - (row_complete ? ROW_CNT : '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            wr_col_reg <= '0;
            wr_sel_reg <= '0;
            rd_col_reg <= '0;
            rd_sel_reg <= '0;
            count_reg  <= '0;
            window_reg <= '0;
            valid_reg  <= 1'b0;
            intr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_col_reg <= wr_col_next;
            wr_sel_reg <= wr_sel_next;
            rd_col_reg <= rd_col_next;
            rd_sel_reg <= rd_sel_next;
            count_reg  <= count_next;
            if (issue) begin
                window_reg <= window_rd;
            end
            valid_reg  <= issue;
            intr_reg   <= row_complete;
        end
    end

    assign o_ready            = ready;
    assign o_pixel_data       = window_reg;
    assign o_pixel_data_valid = valid_reg;
    assign o_intr             = intr_reg;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl (W=8): stream-level reference model checked every cycle,
// reset vector table, directed row-pipeline corner cases and a randomized run.
module tb_conv_window_ctrl;

    localparam int W    = 8;
    localparam int DW   = 12;
    localparam int WINW = 9 * DW;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [DW-1:0]   i_pixel_data = '0;
    logic            i_pixel_data_valid = 1'b0;
    logic            o_ready;
    logic            i_window_ready = 1'b0;
    logic [WINW-1:0] o_pixel_data;
    logic            o_pixel_data_valid;
    logic            o_intr;

    always #5 i_clk = ~i_clk;

    conv_window_ctrl #(
        .INTEGER_BITS     (8),
        .FIXED_POINT_BITS (4),
        .IMG_WIDTH        (W)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_ready            (o_ready),
        .i_window_ready     (i_window_ready),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the accepted pixel stream since reset, rows retired, and a read cursor.
    int              m_cnt    = 0;
    int              m_col    = 0;
    int              m_rows   = 0;
    bit              m_active = 1'b0;
    int              hist[$];
    logic [WINW-1:0] m_data   = '0;

    logic [WINW-1:0] win_log[$];
    int              intr_n       = 0;
    int              not_ready_n  = 0;
    int              cyc          = 0;
    int              last_win_cyc = -1;
    int              intr_cyc     = -2;
    bit              last_ready   = 1'b0;

    typedef struct {
        bit rst;
        bit v;
        int px;
        bit wr;
        bit exp_ready;
        bit exp_valid;
        bit exp_intr;
    } vec_t;

    task automatic check1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic checkw(input string nm, input logic [WINW-1:0] act, input logic [WINW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [WINW-1:0] exp_win(input int r0, input int c0, input int off);
        logic [WINW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                w[(3*r+k)*DW +: DW] = DW'(off + (r0 + r) * 16 + c0 + k);
            end
        end
        return w;
    endfunction

    function automatic logic [WINW-1:0] get_win(input int i);
        if (i < win_log.size()) return win_log[i];
        return '1;
    endfunction

    // One clock cycle: drive, check o_ready, clock, then check registered outputs against the model.
    task automatic step(input bit rst, input bit v, input int px, input bit wr);
        bit              ready_m;
        bit              accept;
        bit              issue;
        bit              complete;
        int              slot;
        logic [WINW-1:0] e;
        i_rst              = rst;
        i_pixel_data_valid = v;
        i_pixel_data       = DW'(px);
        i_window_ready     = wr;
        #1;
        ready_m    = !rst && (m_cnt < 4 * W);
        last_ready = o_ready;
        if (!o_ready) not_ready_n++;
        check1("o_ready", o_ready, ready_m);
        accept   = v && ready_m;
        issue    = !rst && m_active && wr;
        complete = issue && (m_col == W - 3);
        e        = m_data;
        if (issue) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    slot = (m_rows + r) * W + m_col + k;
                    e[(3*r+k)*DW +: DW] = (slot < hist.size()) ? DW'(hist[slot]) : '0;
                end
            end
        end
        @(posedge i_clk);
        #1;
        cyc++;
        if (rst) begin
            e        = '0;
            issue    = 1'b0;
            complete = 1'b0;
            m_cnt    = 0;
            m_col    = 0;
            m_rows   = 0;
            m_active = 1'b0;
            hist.delete();
        end else begin
            if (!m_active) m_active = (m_cnt >= 3 * W);
            else if (complete) m_active = 1'b0;
            m_cnt = m_cnt + (accept ? 1 : 0) - (complete ? W : 0);
            if (issue) m_col = complete ? 0 : m_col + 1;
            if (complete) m_rows++;
            if (accept) hist.push_back(px & 'hFFF);
        end
        m_data = e;
        check1("o_pixel_data_valid", o_pixel_data_valid, issue);
        check1("o_intr", o_intr, complete);
        checkw("o_pixel_data", o_pixel_data, e);
        if (o_pixel_data_valid) begin
            win_log.push_back(o_pixel_data);
            last_win_cyc = cyc;
        end
        if (o_intr) begin
            intr_n++;
            intr_cyc = cyc;
        end
    endtask

    task automatic phase_clear();
        win_log.delete();
        intr_n      = 0;
        not_ready_n = 0;
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, wr);
    endtask

    task automatic feed_rows(input int r_first, input int r_last, input int off, input bit wr);
        for (int r = r_first; r <= r_last; r++) begin
            for (int c = 0; c < W; c++) step(1'b0, 1'b1, off + r * 16 + c, wr);
        end
    endtask

    initial begin
        vec_t tbl[6];
        bit   got;
        int   wr_pct;

        for (int i = 0; i < 6; i++) begin
            tbl[i] = '{rst: (i < 3), v: (i < 3), px: 'h123, wr: 1'b1,
                       exp_ready: (i >= 3), exp_valid: 1'b0, exp_intr: 1'b0};
        end

        // Reset held with valid pixels driven, then released.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].px, tbl[i].wr);
            check1("tbl_ready", last_ready, tbl[i].exp_ready);
            check1("tbl_valid", o_pixel_data_valid, tbl[i].exp_valid);
            check1("tbl_intr", o_intr, tbl[i].exp_intr);
            $display("vec %0d: rst=%0b v=%0b ready=%0b valid=%0b intr=%0b",
                     i, tbl[i].rst, tbl[i].v, last_ready, o_pixel_data_valid, o_intr);
        end

        // Single image of three rows.
        phase_clear();
        feed_rows(0, 2, 0, 1'b1);
        idle(12, 1'b1);
        checki("single_windows", win_log.size(), 6);
        checki("single_intr", intr_n, 1);
        checkw("single_first", get_win(0), exp_win(0, 0, 0));
        checkw("single_last", get_win(5), exp_win(0, 5, 0));
        checki("single_intr_align", intr_cyc, last_win_cyc);
        $display("single image: windows=%0d intr=%0d", win_log.size(), intr_n);

        // Continuous 10-row stream.
        step(1'b1, 1'b0, 0, 1'b0);
        phase_clear();
        feed_rows(0, 9, 0, 1'b1);
        checki("cont_ready_never_low", not_ready_n, 0);
        idle(20, 1'b1);
        checki("cont_intr", intr_n, 8);
        checki("cont_windows", win_log.size(), 48);
        checkw("cont_wrap_first", get_win(24), exp_win(4, 0, 0));
        checkw("cont_last", get_win(47), exp_win(7, 5, 0));
        $display("continuous: windows=%0d intr=%0d", win_log.size(), intr_n);

        // Backpressure: fill all four buffers, then one pixel that must be dropped.
        step(1'b1, 1'b0, 0, 1'b0);
        phase_clear();
        feed_rows(0, 3, 0, 1'b0);
        step(1'b0, 1'b1, 'hFFF, 1'b0);
        check1("bp_ready_low", last_ready, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            if (intr_n > 0) got = 1'b1;
        end
        check1("bp_intr_seen", got, 1'b1);
        checki("bp_windows_at_intr", win_log.size(), 6);
        check1("bp_ready_after", o_ready, 1'b1);
        idle(10, 1'b1);
        checkw("bp_next_row1", get_win(6), exp_win(1, 0, 0));
        feed_rows(4, 4, 0, 1'b1);
        idle(12, 1'b1);
        checkw("bp_row2_group", get_win(12), exp_win(2, 0, 0));
        $display("backpressure: windows=%0d intr=%0d", win_log.size(), intr_n);

        // Accept in the same cycle as the completing issue at count 4W-1.
        step(1'b1, 1'b0, 0, 1'b0);
        phase_clear();
        feed_rows(0, 2, 0, 1'b0);
        for (int c = 0; c < W - 1; c++) step(1'b0, 1'b1, 3 * 16 + c, 1'b0);
        idle(W - 3, 1'b1);
        step(1'b0, 1'b1, 3 * 16 + W - 1, 1'b1);
        idle(20, 1'b1);
        checki("simul_intr", intr_n, 2);
        checki("simul_windows", win_log.size(), 12);
        checkw("simul_restart", get_win(6), exp_win(1, 0, 0));
        checkw("simul_last", get_win(11), exp_win(1, 5, 0));
        $display("accept+retire: windows=%0d intr=%0d", win_log.size(), intr_n);

        // Reset in the middle of a row's windows.
        step(1'b1, 1'b0, 0, 1'b0);
        phase_clear();
        feed_rows(0, 2, 0, 1'b0);
        idle(1, 1'b0);
        idle(3, 1'b1);
        checki("midrst_pre_windows", win_log.size(), 3);
        step(1'b1, 1'b0, 0, 1'b1);
        check1("midrst_valid", o_pixel_data_valid, 1'b0);
        phase_clear();
        idle(10, 1'b1);
        checki("midrst_no_intr", intr_n, 0);
        feed_rows(0, 2, 'h800, 1'b1);
        idle(12, 1'b1);
        checki("midrst_windows", win_log.size(), 6);
        checkw("midrst_first", get_win(0), exp_win(0, 0, 'h800));
        checkw("midrst_last", get_win(5), exp_win(0, 5, 'h800));
        $display("mid-read reset: windows=%0d intr=%0d", win_log.size(), intr_n);

        // Randomized traffic with occasional resets.
        step(1'b1, 1'b0, 0, 1'b0);
        phase_clear();
        for (int i = 0; i < 1500; i++) begin
            wr_pct = (i < 700) ? 4 : 8;
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 4095)),
                 ($urandom_range(0, 9) < wr_pct));
        end
        $display("random: windows=%0d intr=%0d not_ready_cycles=%0d",
                 win_log.size(), intr_n, not_ready_n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
